// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: hold levels, FSM states and bus widths.
package pipe_ctrl_pkg;

    localparam int HOLD_FLAG_BUS = 3;
    localparam int INST_ADDR_BUS = 32;
    localparam int FLUSH_CNT_W   = 4;
    localparam int STALL_CNT_W   = 16;

    localparam logic [INST_ADDR_BUS-1:0] ZERO_WORD = '0;

    // Hold levels are ordered: a higher value also freezes every stage below it.
    typedef enum logic [HOLD_FLAG_BUS-1:0] {
        HOLD_NONE = 3'd0,
        HOLD_PC   = 3'd1,
        HOLD_IF   = 3'd2,
        HOLD_ID   = 3'd3
    } hold_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/stall_wdog.sv
// Fetch-stall watchdog: counts consecutive bus-not-ready cycles and raises a
// sticky flag once the count reaches STALL_MAX.
module stall_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_bus_i,
    output logic stall_timeout_o
);

    localparam logic [STALL_CNT_W-1:0] STALL_LIM = STALL_CNT_W'(STALL_MAX);

    logic [STALL_CNT_W-1:0] stall_cnt;

    // Saturating run-length counter plus sticky timeout flag.
    // NOTE: sequential state uses <= so every register samples pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt       <= '0;
            stall_timeout_o <= 1'b0;
        end else begin
            if (!hold_bus_i) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_LIM) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            // The flag sets on the same edge at which the count reaches the limit.
            if (hold_bus_i && (stall_cnt >= STALL_LIM - 1'b1)) begin
                stall_timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: prioritises redirect, interrupt, EX-busy and
// fetch-stall requests into one hold level, owns the PC redirect, the
// post-redirect flush window, interrupt entry and the fetch watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STALL_MAX    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     jump_flag_ex_i,
    input  logic [INST_ADDR_BUS-1:0] jump_addr_ex_i,
    input  logic                     hold_ex_i,
    input  logic                     hold_bus_i,
    input  logic [INST_ADDR_BUS-1:0] ex_inst_addr_i,
    input  logic                     int_req_i,
    input  logic [INST_ADDR_BUS-1:0] int_addr_i,
    output logic [HOLD_FLAG_BUS-1:0] hold_flag_o,
    output logic                     jump_flag_o,
    output logic [INST_ADDR_BUS-1:0] jump_addr_o,
    output logic                     int_ack_o,
    output logic [INST_ADDR_BUS-1:0] epc_o,
    output logic                     stall_timeout_o
);

    // A redirect opens a flush window only when fetch latency needs covering.
    localparam state_e REDIRECT_STATE = (FLUSH_CYCLES > 0) ? FLUSH : RUN;
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
        (FLUSH_CYCLES > 0) ? FLUSH_CNT_W'(FLUSH_CYCLES - 1) : '0;

    state_e                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    hold_e                  hold;
    logic                   int_take;

    // State register and flush counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state and output decode; everything evaluates to 0 while in reset.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        hold        = HOLD_NONE;
        jump_flag_o = 1'b0;
        jump_addr_o = ZERO_WORD;
        int_ack_o   = 1'b0;
        int_take    = 1'b0;

        if (rst) begin
            unique case (state_q)
                RUN: begin
                    if (jump_flag_ex_i) begin
                        jump_flag_o = 1'b1;
                        jump_addr_o = jump_addr_ex_i;
                        hold        = HOLD_ID;
                        state_d     = REDIRECT_STATE;
                        flush_cnt_d = FLUSH_LOAD;
                    end else if (int_req_i && !hold_ex_i) begin
                        int_take    = 1'b1;
                        int_ack_o   = 1'b1;
                        jump_flag_o = 1'b1;
                        jump_addr_o = int_addr_i;
                        hold        = HOLD_ID;
                        state_d     = REDIRECT_STATE;
                        flush_cnt_d = FLUSH_LOAD;
                    end else if (hold_ex_i) begin
                        // A pending interrupt simply waits here until EX frees up.
                        hold = HOLD_ID;
                    end else if (hold_bus_i) begin
                        hold = HOLD_PC;
                    end
                end
                FLUSH: begin
                    if (jump_flag_ex_i) begin
                        // A new redirect restarts the whole flush window.
                        jump_flag_o = 1'b1;
                        jump_addr_o = jump_addr_ex_i;
                        hold        = HOLD_ID;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        hold = hold_ex_i ? HOLD_ID : HOLD_IF;
                        if (flush_cnt_q == '0) begin
                            state_d = RUN;
                        end else begin
                            flush_cnt_d = flush_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign hold_flag_o = hold;

    // Return address captured on interrupt acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc_o <= ZERO_WORD;
        end else if (int_take) begin
            epc_o <= ex_inst_addr_i;
        end
    end

    stall_wdog #(
        .STALL_MAX(STALL_MAX)
    ) u_stall_wdog (
        .clk            (clk),
        .rst            (rst),
        .hold_bus_i     (hold_bus_i),
        .stall_timeout_o(stall_timeout_o)
    );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the RV32 core.
- Merges hold and redirect requests from EX (branch/jump, multi-cycle divide), the instruction bus (fetch stall) and the interrupt line into one prioritised hold_flag_o.
- hold_flag_o drives the PC, IF/ID and ID/EX pipeline registers. A register with an active hold loads its NOP/zero default, so a hold acts as a flush.
- Owns PC redirect (jump_flag_o/jump_addr_o), post-redirect flush sequencing, interrupt entry handshake and a fetch-stall watchdog.

Parameters:
- FLUSH_CYCLES, 1: extra cycles HOLD_IF is kept after a redirect, covering synchronous fetch latency. Legal range 0..15.
- STALL_MAX, 255: consecutive hold_bus_i cycles before stall_timeout_o sets. Legal range 1..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- jump_flag_ex_i  in  1  EX resolved a taken branch/jump this cycle
- jump_addr_ex_i  in  32  EX redirect target
- hold_ex_i  in  1  EX busy (divider running)
- hold_bus_i  in  1  instruction bus not ready
- ex_inst_addr_i  in  32  address of the instruction currently in EX
- int_req_i  in  1  level interrupt request
- int_addr_i  in  32  interrupt vector
- hold_flag_o  out  3  NONE=0, PC=1, IF=2, ID=3
- jump_flag_o  out  1  PC redirect strobe
- jump_addr_o  out  32  PC redirect target
- int_ack_o  out  1  one-cycle interrupt-taken strobe
- epc_o  out  32  registered return address for the interrupt
- stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, flush counter=0, stall counter=0.
  - epc_o=0, stall_timeout_o=0.
  - All combinational outputs evaluate to 0.
- States: RUN, FLUSH.
- RUN, combinational, highest priority first:
  1. jump_flag_ex_i=1: jump_flag_o=1, jump_addr_o=jump_addr_ex_i, hold_flag_o=HOLD_ID. Next state is FLUSH if FLUSH_CYCLES>0, else RUN.
  2. int_req_i=1 and hold_ex_i=0: int_ack_o=1, jump_flag_o=1, jump_addr_o=int_addr_i, hold_flag_o=HOLD_ID, epc_o<=ex_inst_addr_i. Next state as in rule 1.
  3. hold_ex_i=1: hold_flag_o=HOLD_ID. An interrupt stays pending until hold_ex_i drops; it is never dropped.
  4. hold_bus_i=1: hold_flag_o=HOLD_PC.
  5. Otherwise: HOLD_NONE.
- FLUSH:
  - hold_flag_o=HOLD_IF for exactly FLUSH_CYCLES cycles, counted by a counter loaded with FLUSH_CYCLES-1 on entry. Return to RUN when the counter reaches 0.
  - int_ack_o is never asserted in FLUSH.
  - A jump_flag_ex_i in FLUSH is still honoured: jump_flag_o=1, hold_flag_o=HOLD_ID, counter reloads.
  - hold_ex_i in FLUSH raises the hold to HOLD_ID. The counter still decrements.
- Redirect latency: jump_flag_o/jump_addr_o are combinational, same cycle as the cause. The PC updates on the next edge.
- int_ack_o lasts one cycle per accept. If int_req_i is still high after the return to RUN, it is accepted again; software is expected to clear the source.
- Watchdog:
  - Stall counter is 16 bits. It increments while hold_bus_i=1 and clears when hold_bus_i=0.
  - When it reaches STALL_MAX it saturates and stall_timeout_o<=1. stall_timeout_o clears only on reset.
- Reset asserted mid-FLUSH or mid-stall: all state clears immediately; epc_o is lost.

Decomposition:
- Shared defines file: HOLD_NONE/PC/IF/ID, HOLD_FLAG_BUS, INST_ADDR_BUS, ZERO_WORD, state encodings RUN=1'b0, FLUSH=1'b1.
- One sub-module, stall_wdog: the saturating counter plus sticky flag. Its inputs are clk, rst, hold_bus_i; its output is stall_timeout_o.

Test Plan:
1. Reset with all inputs idle, then release -> hold_flag_o=0, jump_flag_o=0, epc_o=0, stall_timeout_o=0.
2. jump_flag_ex_i=1, jump_addr_ex_i=0x0000_0100 for 1 cycle, FLUSH_CYCLES=1 -> cycle 0: jump_flag_o=1, jump_addr_o=0x100, hold=3; cycle 1: hold=2; cycle 2: hold=0.
3. hold_ex_i=1 for 5 cycles with int_req_i=1 (vector 0x80, ex_inst_addr_i=0x44) -> hold=3 and no ack for 5 cycles; on cycle 6: int_ack_o=1 for one cycle, jump_addr_o=0x80, epc_o=0x44.
4. Jump (0x200) and int_req_i in the same cycle -> jump wins, jump_addr_o=0x200, no ack; ack follows on the first RUN cycle after the flush.
5. hold_bus_i=1 held continuously, STALL_MAX=4 -> hold=1 throughout; stall_timeout_o rises after the 4th cycle and stays 1 after hold_bus_i drops.
6. rst pulsed low during FLUSH -> outputs 0 asynchronously; after release the state is RUN and hold=0.
